cam_pixel_capture: RTL and testbench

Parametrised next-generation OV7670 byte capture front end. Samples the camera bus (PCLK/HREF/VSYNC/data) in the system clock domain and selects bytes by runtime mode: luminance only, all bytes, or decimated luminance. Optionally inserts a unique frame-start marker. Buffers the selected bytes in a FIFO and presents them on a valid/ready stream to the UART transmitter, with overflow reporting.

---
 rtl/cam_pkg.sv | 13 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/cam_pixel_capture.sv | 106 ++++++++++
 tb/tb_cam_pixel_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared modes, default marker byte and sizing helper for the camera capture path
package cam_pkg;
  typedef enum logic [1:0] {
    MODE_Y     = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_DECIM = 2'd2,
    MODE_OFF   = 2'd3
  } cam_mode_e;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hFF;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head byte and no fall-through
module sync_fifo
  import cam_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = addr_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0] count, rem;
  logic pop, wr;
  always_comb begin
    empty  = count == '0;
    full   = count == (AW+1)'(DEPTH);
    pop    = !empty && ready;
    wr     = push && (!full || pop);
    rd_nxt = rd_ptr + AW'(pop);
    rem    = count - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  // head register loads the next stored entry, or the incoming byte when that becomes the only entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_nxt;
      count  <= rem + (AW+1)'(wr);
      if (rem != '0) dout <= mem[rd_nxt];
      else if (wr) dout <= din;
    end
  end
endmodule

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: synchronises the OV7670 bus, selects bytes by mode and buffers them for the UART
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int               DATA_W      = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               FIFO_DEPTH  = 16,
  parameter int               DECIM       = 2,
  parameter int               HDR_EN      = 1,
  parameter logic [DATA_W-1:0] HDR_BYTE   = DATA_W'(HDR_BYTE_DEF),
  parameter int               CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pclk,
  input  logic              href,
  input  logic              vsync,
  input  logic [DATA_W-1:0] pixel,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  logic [SYNC_STAGES-1:0] pclk_s, href_s, vsync_s;
  logic [DATA_W-1:0] pix_d [SYNC_STAGES+1];
  logic [DATA_W-1:0] pix_sel, push_data;
  logic [PW-1:0] pix_cnt;
  logic pclk_prev, edge_q, href_q, vsync_q, vsync_prev;
  logic armed, phase, push_q, fs, cap, keep, empty, full, drop;
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_s     <= '0;
      href_s     <= '0;
      vsync_s    <= '0;
      pclk_prev  <= 1'b0;
      edge_q     <= 1'b0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      vsync_prev <= 1'b0;
      for (int i = 0; i <= SYNC_STAGES; i++) pix_d[i] <= '0;
    end else begin
      pclk_s     <= {pclk_s[SYNC_STAGES-2:0], pclk};
      href_s     <= {href_s[SYNC_STAGES-2:0], href};
      vsync_s    <= {vsync_s[SYNC_STAGES-2:0], vsync};
      pclk_prev  <= pclk_s[SYNC_STAGES-1];
      edge_q     <= pclk_s[SYNC_STAGES-1] && !pclk_prev;
      href_q     <= href_s[SYNC_STAGES-1];
      vsync_q    <= vsync_s[SYNC_STAGES-1];
      vsync_prev <= vsync_q;
      pix_d[0]   <= pixel;
      for (int i = 1; i <= SYNC_STAGES; i++) pix_d[i] <= pix_d[i-1];
    end
  end
  // pix_d[SYNC_STAGES] lines up with edge_q, so the byte is taken at the pclk rise it belongs to
  always_comb begin
    fs      = vsync_prev && !vsync_q;
    cap     = edge_q && href_q && !vsync_q && armed && mode != MODE_OFF;
    keep    = mode == MODE_ALL ? 1'b1 :
              mode == MODE_Y ? !phase :
              mode == MODE_DECIM ? (!phase && pix_cnt == '0) : 1'b0;
    pix_sel = (HDR_EN != 0 && pix_d[SYNC_STAGES] == HDR_BYTE) ? HDR_BYTE - 1'b1 : pix_d[SYNC_STAGES];
    drop    = push_q && full && !(out_valid && out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      push_q    <= 1'b0;
      push_data <= '0;
      phase     <= 1'b0;
      pix_cnt   <= '0;
      armed     <= 1'b0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      push_q    <= (fs && HDR_EN != 0) || (cap && keep);
      push_data <= fs ? HDR_BYTE : pix_sel;
      if (!href_q || vsync_q) begin
        phase   <= 1'b0;
        pix_cnt <= '0;
      end else if (cap) begin
        phase <= !phase;
        if (phase) pix_cnt <= pix_cnt == PW'(DECIM - 1) ? '0 : pix_cnt + 1'b1;
      end
      if (fs) begin
        armed     <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
      end
      // a drop always wins, so a marker lost right after frame start still reports
      if (drop) overflow <= 1'b1;
      else if (fs) overflow <= 1'b0;
    end
  end
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_q),
    .din  (push_data),
    .ready(out_ready),
    .dout (out_data),
    .empty(empty),
    .full (full)
  );
  assign out_valid = !empty;
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb_cam_pixel_capture: directed camera traffic against a queue model, with and without the frame marker
module tb_cam_pixel_capture;
  localparam int DECIM = 2;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, pclk = 0, href = 0, vsync = 1, out_ready = 0;
  logic [7:0] pixel = 0;
  logic [1:0] mode = 0;
  logic [7:0] d0, d1;
  logic v0, v1, o0, o1;
  logic [15:0] f0, f1;
  int errs = 0, checks = 0, rmode = 0, li = 0, fcnt = 0;
  bit arm = 0, mo0 = 0, mo1 = 0;
  logic [7:0] q0[$], q1[$], g0[$], g1[$], e[$];

  always #5 clk = ~clk;

  cam_pixel_capture #(.HDR_EN(1)) u0 (
    .clk(clk), .rst(rst), .pclk(pclk), .href(href), .vsync(vsync), .pixel(pixel), .mode(mode),
    .out_data(d0), .out_valid(v0), .out_ready(out_ready), .overflow(o0), .frame_cnt(f0));
  cam_pixel_capture #(.HDR_EN(0)) u1 (
    .clk(clk), .rst(rst), .pclk(pclk), .href(href), .vsync(vsync), .pixel(pixel), .mode(mode),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready), .overflow(o1), .frame_cnt(f1));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic check_stream(input string n, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({n, " len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(n, got[i], exp[i]);
  endtask

  // model FIFO: what each instance must eventually emit, with drops when it would be full
  function automatic void mpush(input logic [7:0] b, input bit marker);
    logic [7:0] v;
    v = marker ? 8'hFF : (b == 8'hFF ? 8'hFE : b);
    if (q0.size() >= DEPTH) mo0 = 1; else q0.push_back(v);
    if (!marker) begin
      if (q1.size() >= DEPTH) mo1 = 1; else q1.push_back(b);
    end
  endfunction

  task automatic frame_start();
    vsync = 1;
    tick(4);
    vsync = 0;
    arm = 1; mo0 = 0; mo1 = 0; fcnt++;
    mpush(8'h00, 1);
    tick(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit keep;
    pixel = b;
    pclk = 0;
    tick(2);
    pclk = 1;
    if (href && arm && mode != 2'd3) begin
      keep = mode == 2'd1 || (mode == 2'd0 && li % 2 == 0) || (mode == 2'd2 && li % 2 == 0 && (li / 2) % DECIM == 0);
      if (keep) mpush(b, 0);
      li++;
    end
    tick(3);
    pclk = 0;
  endtask

  task automatic send_line(input logic [7:0] bytes[$]);
    href = 1; li = 0;
    tick(2);
    foreach (bytes[i]) send_byte(bytes[i]);
    tick(2);
    href = 0;
    tick(3);
  endtask

  task automatic drain();
    int i;
    rmode = 1;
    for (i = 0; i < 300 && !(q0.size() == 0 && q1.size() == 0 && !v0 && !v1); i++) tick(1);
    tick(4);
    check("drain model0", q0.size(), 0);
    check("drain model1", q1.size(), 0);
    check("drain valid0", v0, 0);
  endtask

  task automatic clr();
    g0.delete(); g1.delete();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rmode == 2 ? ~out_ready : (rmode == 1);
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (v0 && out_ready) begin
        g0.push_back(d0);
        checks++;
        if (q0.size() == 0) begin errs++; $display("FAIL stream0 extra byte: got %0h expected none", d0); end
        else if (d0 !== q0[0]) begin errs++; $display("FAIL stream0: got %0h expected %0h", d0, q0.pop_front()); end
        else void'(q0.pop_front());
      end
      if (v1 && out_ready) begin
        g1.push_back(d1);
        checks++;
        if (q1.size() == 0) begin errs++; $display("FAIL stream1 extra byte: got %0h expected none", d1); end
        else if (d1 !== q1[0]) begin errs++; $display("FAIL stream1: got %0h expected %0h", d1, q1.pop_front()); end
        else void'(q1.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] line[$];
    tick(3);
    check("reset valid", v0, 0);
    check("reset data", d0, 0);
    check("reset overflow", o0, 0);
    check("reset frame_cnt", f0, 0);
    rst = 0;
    tick(4);
    // basic Y-only line with marker
    rmode = 1; mode = 0; clr();
    frame_start();
    line = {8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    send_line(line);
    drain();
    e = {8'hFF, 8'h10, 8'h11, 8'h12}; check_stream("y_only", g0, e);
    e = {8'h10, 8'h11, 8'h12}; check_stream("y_only nohdr", g1, e);
    check("frame_cnt 1", f0, 1);
    check("overflow t1", o0, 0);
    // all bytes, then decimated luminance
    mode = 1; clr();
    frame_start(); send_line(line); drain();
    e = {8'hFF, 8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22}; check_stream("all", g0, e);
    mode = 2; clr();
    frame_start(); send_line(line); drain();
    e = {8'hFF, 8'h10, 8'h12}; check_stream("decim", g0, e);
    check("frame_cnt 3", f0, fcnt);
    // reset in the middle of a line: nothing until a full frame start
    mode = 0;
    href = 1; li = 0; tick(2);
    send_byte(8'h33); tick(6);
    rst = 1; tick(3);
    arm = 0; fcnt = 0; mo0 = 0; mo1 = 0; q0.delete(); q1.delete(); clr();
    rst = 0;
    tick(1);
    check("rst frame_cnt", f0, 0);
    li = 0;
    send_byte(8'h30); send_byte(8'h31);
    href = 0; tick(10);
    check("disarmed valid", v0, 0);
    check("disarmed count", g0.size(), 0);
    frame_start();
    line = {8'h40, 8'h41}; send_line(line); drain();
    e = {8'hFF, 8'h40}; check_stream("rearm", g0, e);
    e = {8'h40}; check_stream("rearm nohdr", g1, e);
    // fill with no reader: overflow, marker dropped at a full frame start, then cleared
    mode = 1; rmode = 0; clr();
    frame_start();
    line.delete();
    for (int i = 0; i < 20; i++) line.push_back(8'h50 + 8'(i));
    send_line(line);
    tick(10);
    check("overflow set", o0, 1);
    check("overflow model0", o0, mo0);
    check("overflow model1", o1, mo1);
    frame_start();
    check("overflow marker drop", o0, 1);
    check("overflow nohdr clear", o1, 0);
    drain();
    check("full len", g0.size(), 16);
    check("full first", g0[0], 8'hFF);
    check("full last", g0[15], 8'h5E);
    check("full nohdr last", g1[15], 8'h5F);
    frame_start();
    check("overflow cleared", o0, 0);
    drain();
    // marker uniqueness
    clr();
    frame_start();
    line = {8'h01, 8'hFF}; send_line(line); drain();
    e = {8'hFF, 8'h01, 8'hFE}; check_stream("clamp", g0, e);
    e = {8'h01, 8'hFF}; check_stream("clamp nohdr", g1, e);
    // fill to exactly full, then a toggling reader while more bytes arrive
    rst = 1; tick(3);
    arm = 0; fcnt = 0; q0.delete(); q1.delete(); clr();
    rst = 0; vsync = 1; tick(2);
    rmode = 0;
    frame_start();
    line.delete();
    for (int i = 0; i < 15; i++) line.push_back(8'h60 + 8'(i));
    send_line(line);
    tick(8);
    check("full no overflow", o0, 0);
    rmode = 2;
    line.delete();
    for (int i = 0; i < 10; i++) line.push_back(8'h80 + 8'(i));
    send_line(line);
    check("toggle overflow", o0, 0);
    frame_start(); frame_start(); frame_start();
    drain();
    check("toggle overflow end", o0, 0);
    check("frame_cnt 4", f0, 4);
    check("frame_cnt 4 nohdr", f1, 4);
    check("toggle total", g0.size(), 29);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
